reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised reset controller for a single clock domain. Merges `NUM_SRC` asynchronous active-low reset requests and a synchronous software reset request. It drives `NUM_CH` active-low reset outputs that assert together and release one by one in a staggered order after a guaranteed minimum assert time. It sits at the top of each clock domain, below the power-on reset, and feeds per-subsystem resets. Each request source has a sticky cause bit.

## Interface
Parameters:
- `NUM_SRC`, 2: number of asynchronous reset request inputs (≥1)
- `SYNC_STAGES`, 2: synchroniser depth per request input (≥2)
- `NUM_CH`, 4: number of reset outputs (≥1)
- `MIN_ASSERT`, 16: cycles all outputs stay asserted after the last active request (≥1)
- `STAGGER`, 8: cycles between successive channel releases (≥1)
- `CNT_W`, 8: counter width; must hold max(`MIN_ASSERT`, `STAGGER`)

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  reset, synchronous, active-low
- `rst_req_n`  in  `NUM_SRC`  asynchronous reset requests, active-low, one per source
- `sw_rst`  in  1  synchronous software reset request, active-high, level
- `cause_clr`  in  1  synchronous pulse; clears `rst_cause`
- `rst_out_n`  out  `NUM_CH`  reset outputs, active-low, registered; bit 0 releases first
- `seq_done`  out  1  high once all channels are released
- `rst_cause`  out  `NUM_SRC`+1  sticky cause bits: bit i = `rst_req_n[i]`, bit `NUM_SRC` = `sw_rst`

## Operation
- **Synchronisers.** Each `rst_req_n[i]` passes through its own `SYNC_STAGES`-flop chain, giving `req_sync[i]`.
  - Reset value of every chain flop is 0, meaning "request active".
- **Request.** `req_act` = any(~`req_sync`) | `sw_rst`.
- **FSM states:** ASSERT, HOLD, RELEASE, DONE.
  - ASSERT: all `rst_out_n`=0 and `seq_done`=0. Leave to HOLD on the first edge where `req_act`=0; counter cleared.
  - HOLD: the counter counts up each cycle. Move to RELEASE when the count reaches `MIN_ASSERT`−1.
    - On that transition, `rst_out_n[0]` goes to 1 and the channel index becomes 1.
  - RELEASE: the counter counts `STAGGER` cycles per step. At each step end, release `rst_out_n[idx]` and increment `idx`.
    - When channel `NUM_CH`−1 releases, go to DONE and set `seq_done`=1 on the same edge.
    - If `NUM_CH`=1, HOLD goes straight to DONE.
  - DONE: all outputs 1; hold until a new request.
- **Retrigger.** `req_act`=1 in any state moves the FSM to ASSERT on that edge.
  - All `rst_out_n` go to 0, `seq_done` goes to 0, and the counter and index clear.
  - A new request fully restarts the `MIN_ASSERT` window.
- **Released channels stay released** until a retrigger. The release order is fixed: bit 0 upward.
- **Cause bits.** On each edge, bit i is set when ~`req_sync[i]`, and bit `NUM_SRC` is set when `sw_rst`.
  - `cause_clr` clears all bits.
  - If a set and `cause_clr` occur on the same edge, set wins for that bit.
- **Reset.** While `reset_n`=0:
  - state = ASSERT, `rst_out_n` = all 0, `seq_done` = 0, `rst_cause` = 0, counter and index = 0, sync flops = 0.
  - Because the sync flops reset to 0, the post-reset sequence runs automatically.
  - `rst_cause` stays 0 after `reset_n` because `req_sync` is excluded from cause setting while the chains refill. A cause bit sets only when a request is seen after the chain reads 1 once. Use a per-source `armed` flag, cleared by `reset_n` and set when `req_sync[i]`=1.

## Timing
- **`sw_rst` latency.** `sw_rst` sampled high at edge E gives `rst_out_n`=0 from E (visible after E).
- **Async request latency.** `rst_req_n[i]` low and stable before edge E gives `rst_out_n`=0 from edge E+`SYNC_STAGES`−1+1, i.e. `SYNC_STAGES` edges of latency.
- **Release timing.** Let L be the last edge with `req_act`=1.
  - `rst_out_n[k]` rises at edge L+`MIN_ASSERT`+k·`STAGGER`.
  - `seq_done` rises at edge L+`MIN_ASSERT`+(`NUM_CH`−1)·`STAGGER`.
- **After `reset_n`.** Let R be the first edge with `reset_n`=1. Then L = R+`SYNC_STAGES`−1.
- **Glitch-free outputs.** All outputs come from flops, with no combinational path from inputs.

## Test plan
- **Power-up, defaults.** Release `reset_n` at edge R → `rst_out_n` rises one bit at a time at edges R+17, R+25, R+33, R+41 (0x1, 0x3, 0x7, 0xF); `seq_done`=1 at R+41; `rst_cause`=0.
- **Software reset from DONE.** `sw_rst` high for 3 cycles at edges E..E+2 → `rst_out_n`=0x0 and `seq_done`=0 after E; bit 0 rises at E+18; `rst_cause`=0b100.
- **Async request from DONE.** `rst_req_n`=2'b01 for 5 cycles → outputs assert 2 edges after the fall; release starts 16 edges after the last active `req_sync`; `rst_cause`=0b010.
- **Retrigger mid-release.** After `rst_out_n`=0x3, pulse `sw_rst` for 1 cycle → `rst_out_n`=0x0 next edge; full 16 + 3·8 sequence repeats.
- **Cause clear.** `cause_clr` pulse with no request → `rst_cause`=0. `cause_clr` coincident with `sw_rst` → bit 2 stays 1.
- **Parameter sweep.** `NUM_CH`=1, `MIN_ASSERT`=1, `STAGGER`=1, `SYNC_STAGES`=3 → `rst_out_n` and `seq_done` rise together at L+1. Check that `reset_n` asserted mid-HOLD returns all outputs to reset values on that edge.

Source files
------------

// File: rtl/reset_sequencer.sv
// Reset sequencer for one clock domain: merges async and software reset requests,
// holds all channel resets for a minimum window, then releases them one by one.
module reset_sequencer #(
  parameter int NUM_SRC     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = 4,
  parameter int MIN_ASSERT  = 16,
  parameter int STAGGER     = 8,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_SRC-1:0] rst_req_n,
  input  logic              sw_rst,
  input  logic              cause_clr,
  output logic [NUM_CH-1:0] rst_out_n,
  output logic              seq_done,
  output logic [NUM_SRC:0]  rst_cause
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // HOLD is entered one edge into the window, so it ends one count early.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MIN_ASSERT >= 2) ? MIN_ASSERT - 2 : 0);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                           state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [NUM_CH-1:0]                rst_out_n_q, rst_out_n_d;
  logic                             seq_done_q, seq_done_d;
  logic [NUM_SRC:0]                 rst_cause_q, rst_cause_d;
  logic [NUM_SRC-1:0]               armed_q, armed_d;
  logic [NUM_SRC-1:0][SYNC_STAGES-1:0] sync_q;
  logic [NUM_SRC-1:0]               req_sync;
  logic                             req_act;
  logic                             win_end;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      req_sync[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  assign req_act = (|(~req_sync)) | sw_rst;

  // A source may only record a cause once its chain has shown "idle" after reset.
  assign armed_d     = armed_q | req_sync;
  assign rst_cause_d = (cause_clr ? '0 : rst_cause_q) | {sw_rst, armed_q & ~req_sync};

  assign win_end = ((state_q == ST_ASSERT) && (MIN_ASSERT == 1)) ||
                   ((state_q == ST_HOLD) && (cnt_q == HOLD_LAST));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rst_out_n_d = rst_out_n_q;
    seq_done_d  = seq_done_q;
    if (req_act) begin
      state_d     = ST_ASSERT;
      cnt_d       = '0;
      idx_d       = '0;
      rst_out_n_d = '0;
      seq_done_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_ASSERT, ST_HOLD: begin
          state_d = ST_HOLD;
          cnt_d   = (state_q == ST_HOLD) ? cnt_q + CNT_W'(1) : '0;
          if (win_end) begin
            rst_out_n_d[0] = 1'b1;
            cnt_d          = '0;
            if (NUM_CH == 1) begin
              state_d    = ST_DONE;
              seq_done_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              idx_d   = IDX_W'(1);
            end
          end
        end
        ST_RELEASE: begin
          if (cnt_q == STEP_LAST) begin
            cnt_d              = '0;
            rst_out_n_d[idx_q] = 1'b1;
            if (idx_q == LAST_CH) begin
              state_d    = ST_DONE;
              seq_done_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_ASSERT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_ASSERT;
      cnt_q       <= '0;
      idx_q       <= '0;
      rst_out_n_q <= '0;
      seq_done_q  <= 1'b0;
      rst_cause_q <= '0;
      armed_q     <= '0;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rst_out_n_q <= rst_out_n_d;
      seq_done_q  <= seq_done_d;
      rst_cause_q <= rst_cause_d;
      armed_q     <= armed_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], rst_req_n[i]};
      end
    end
  end

  assign rst_out_n = rst_out_n_q;
  assign seq_done  = seq_done_q;
  assign rst_cause = rst_cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: default instance plus a minimal-parameter instance.
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  logic       reset_n, sw_rst, cause_clr;
  logic [1:0] rst_req_n;
  logic [3:0] rst_out_n;
  logic       seq_done;
  logic [2:0] rst_cause;

  logic       reset_n2, sw_rst2, cause_clr2;
  logic [1:0] rst_req_n2;
  logic [0:0] rst_out_n2;
  logic       seq_done2;
  logic [2:0] rst_cause2;

  reset_sequencer #(
    .NUM_SRC(2), .SYNC_STAGES(2), .NUM_CH(4), .MIN_ASSERT(16), .STAGGER(8), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rst_req_n(rst_req_n), .sw_rst(sw_rst),
    .cause_clr(cause_clr), .rst_out_n(rst_out_n), .seq_done(seq_done), .rst_cause(rst_cause)
  );

  reset_sequencer #(
    .NUM_SRC(2), .SYNC_STAGES(3), .NUM_CH(1), .MIN_ASSERT(1), .STAGGER(1), .CNT_W(8)
  ) dut2 (
    .clk(clk), .reset_n(reset_n2), .rst_req_n(rst_req_n2), .sw_rst(sw_rst2),
    .cause_clr(cause_clr2), .rst_out_n(rst_out_n2), .seq_done(seq_done2), .rst_cause(rst_cause2)
  );

  typedef struct {
    int         edge_no;
    logic [3:0] rst;
    logic       done;
    logic [2:0] cause;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic void sb_push(int e, logic [3:0] r, logic d, logic [2:0] c);
    exp_t x;
    x.edge_no = e; x.rst = r; x.done = d; x.cause = c;
    sb.push_back(x);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; sw_rst = 1'b0; cause_clr = 1'b0; rst_req_n = 2'b11;
    reset_n2 = 1'b0; sw_rst2 = 1'b0; cause_clr2 = 1'b0; rst_req_n2 = 2'b11;
    repeat (3) @(negedge clk);
    checks++;
    if (rst_out_n !== 4'h0) begin failures++; $display("FAIL reset rst_out_n got %h want 0", rst_out_n); end
    checks++;
    if (seq_done !== 1'b0) begin failures++; $display("FAIL reset seq_done got %b want 0", seq_done); end
    checks++;
    if (rst_cause !== 3'b000) begin failures++; $display("FAIL reset rst_cause got %b want 000", rst_cause); end
    checks++;
    if ({rst_out_n2, seq_done2} !== 2'b00) begin
      failures++; $display("FAIL reset dut2 out/done got %b want 00", {rst_out_n2, seq_done2});
    end
  endtask

  task automatic test_power_up();
    exp_t e;
    int r;
    @(negedge clk);
    reset_n = 1'b1;
    r = edge_n + 1;
    sb_push(r+16, 4'h0, 0, 3'b000); sb_push(r+17, 4'h1, 0, 3'b000);
    sb_push(r+24, 4'h1, 0, 3'b000); sb_push(r+25, 4'h3, 0, 3'b000);
    sb_push(r+33, 4'h7, 0, 3'b000); sb_push(r+40, 4'h7, 0, 3'b000);
    sb_push(r+41, 4'hF, 1, 3'b000);
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].edge_no == edge_n) begin
        e = sb.pop_front();
        checks += 3;
        if (rst_out_n !== e.rst) begin failures++; $display("FAIL pwrup rst_out_n @R+%0d got %h want %h", edge_n-r, rst_out_n, e.rst); end
        if (seq_done !== e.done) begin failures++; $display("FAIL pwrup seq_done @R+%0d got %b want %b", edge_n-r, seq_done, e.done); end
        if (rst_cause !== e.cause) begin failures++; $display("FAIL pwrup rst_cause @R+%0d got %b want %b", edge_n-r, rst_cause, e.cause); end
      end
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL pwrup timeout pending %0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_sw_reset();
    exp_t e;
    int x;
    @(negedge clk);
    sw_rst = 1'b1;
    x = edge_n + 1;
    sb_push(x, 4'h0, 0, 3'b100);    sb_push(x+17, 4'h0, 0, 3'b100);
    sb_push(x+18, 4'h1, 0, 3'b100); sb_push(x+26, 4'h3, 0, 3'b100);
    sb_push(x+34, 4'h7, 0, 3'b100); sb_push(x+42, 4'hF, 1, 3'b100);
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].edge_no == edge_n) begin
        e = sb.pop_front();
        checks += 3;
        if (rst_out_n !== e.rst) begin failures++; $display("FAIL swrst rst_out_n @E+%0d got %h want %h", edge_n-x, rst_out_n, e.rst); end
        if (seq_done !== e.done) begin failures++; $display("FAIL swrst seq_done @E+%0d got %b want %b", edge_n-x, seq_done, e.done); end
        if (rst_cause !== e.cause) begin failures++; $display("FAIL swrst rst_cause @E+%0d got %b want %b", edge_n-x, rst_cause, e.cause); end
      end
      if (edge_n == x + 2) sw_rst = 1'b0;
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL swrst timeout pending %0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_cause_clr();
    exp_t e;
    int x;
    @(negedge clk);
    cause_clr = 1'b1;
    x = edge_n + 1;
    sb_push(x, 4'hF, 1, 3'b000);    sb_push(x+1, 4'h0, 0, 3'b100);
    sb_push(x+16, 4'h0, 0, 3'b100); sb_push(x+17, 4'h1, 0, 3'b100);
    sb_push(x+41, 4'hF, 1, 3'b100); sb_push(x+42, 4'hF, 1, 3'b000);
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].edge_no == edge_n) begin
        e = sb.pop_front();
        checks += 3;
        if (rst_out_n !== e.rst) begin failures++; $display("FAIL cclr rst_out_n @+%0d got %h want %h", edge_n-x, rst_out_n, e.rst); end
        if (seq_done !== e.done) begin failures++; $display("FAIL cclr seq_done @+%0d got %b want %b", edge_n-x, seq_done, e.done); end
        if (rst_cause !== e.cause) begin failures++; $display("FAIL cclr rst_cause @+%0d got %b want %b", edge_n-x, rst_cause, e.cause); end
      end
      if (edge_n == x) sw_rst = 1'b1;
      if (edge_n == x + 1) begin sw_rst = 1'b0; cause_clr = 1'b0; end
      if (edge_n == x + 41) cause_clr = 1'b1;
      if (edge_n == x + 42) cause_clr = 1'b0;
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL cclr timeout pending %0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_async_req();
    exp_t e;
    int x;
    @(negedge clk);
    rst_req_n = 2'b01;
    x = edge_n;
    sb_push(x+2, 4'hF, 1, 3'b000);  sb_push(x+3, 4'h0, 0, 3'b010);
    sb_push(x+22, 4'h0, 0, 3'b010); sb_push(x+23, 4'h1, 0, 3'b010);
    sb_push(x+46, 4'h7, 0, 3'b010); sb_push(x+47, 4'hF, 1, 3'b010);
    for (int c = 0; c < 70 && sb.size() > 0; c++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].edge_no == edge_n) begin
        e = sb.pop_front();
        checks += 3;
        if (rst_out_n !== e.rst) begin failures++; $display("FAIL async rst_out_n @+%0d got %h want %h", edge_n-x, rst_out_n, e.rst); end
        if (seq_done !== e.done) begin failures++; $display("FAIL async seq_done @+%0d got %b want %b", edge_n-x, seq_done, e.done); end
        if (rst_cause !== e.cause) begin failures++; $display("FAIL async rst_cause @+%0d got %b want %b", edge_n-x, rst_cause, e.cause); end
      end
      if (edge_n == x + 5) rst_req_n = 2'b11;
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL async timeout pending %0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_retrigger();
    exp_t e;
    int x;
    @(negedge clk);
    sw_rst = 1'b1;
    x = edge_n;
    sb_push(x+1, 4'h0, 0, 3'b110);  sb_push(x+16, 4'h0, 0, 3'b110);
    sb_push(x+17, 4'h1, 0, 3'b110); sb_push(x+25, 4'h3, 0, 3'b110);
    sb_push(x+26, 4'h3, 0, 3'b110); sb_push(x+27, 4'h0, 0, 3'b110);
    sb_push(x+42, 4'h0, 0, 3'b110); sb_push(x+43, 4'h1, 0, 3'b110);
    sb_push(x+51, 4'h3, 0, 3'b110); sb_push(x+59, 4'h7, 0, 3'b110);
    sb_push(x+66, 4'h7, 0, 3'b110); sb_push(x+67, 4'hF, 1, 3'b110);
    for (int c = 0; c < 90 && sb.size() > 0; c++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].edge_no == edge_n) begin
        e = sb.pop_front();
        checks += 3;
        if (rst_out_n !== e.rst) begin failures++; $display("FAIL retrig rst_out_n @+%0d got %h want %h", edge_n-x, rst_out_n, e.rst); end
        if (seq_done !== e.done) begin failures++; $display("FAIL retrig seq_done @+%0d got %b want %b", edge_n-x, seq_done, e.done); end
        if (rst_cause !== e.cause) begin failures++; $display("FAIL retrig rst_cause @+%0d got %b want %b", edge_n-x, rst_cause, e.cause); end
      end
      if (edge_n == x + 1) sw_rst = 1'b0;
      if (edge_n == x + 26) sw_rst = 1'b1;
      if (edge_n == x + 27) sw_rst = 1'b0;
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL retrig timeout pending %0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid_hold();
    exp_t e;
    int x;
    @(negedge clk);
    sw_rst = 1'b1;
    x = edge_n;
    sb_push(x+1, 4'h0, 0, 3'b110);  sb_push(x+5, 4'h0, 0, 3'b110);
    sb_push(x+6, 4'h0, 0, 3'b000);  sb_push(x+24, 4'h0, 0, 3'b000);
    sb_push(x+25, 4'h1, 0, 3'b000); sb_push(x+49, 4'hF, 1, 3'b000);
    for (int c = 0; c < 70 && sb.size() > 0; c++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].edge_no == edge_n) begin
        e = sb.pop_front();
        checks += 3;
        if (rst_out_n !== e.rst) begin failures++; $display("FAIL midhold rst_out_n @+%0d got %h want %h", edge_n-x, rst_out_n, e.rst); end
        if (seq_done !== e.done) begin failures++; $display("FAIL midhold seq_done @+%0d got %b want %b", edge_n-x, seq_done, e.done); end
        if (rst_cause !== e.cause) begin failures++; $display("FAIL midhold rst_cause @+%0d got %b want %b", edge_n-x, rst_cause, e.cause); end
      end
      if (edge_n == x + 1) sw_rst = 1'b0;
      if (edge_n == x + 5) reset_n = 1'b0;
      if (edge_n == x + 7) reset_n = 1'b1;
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL midhold timeout pending %0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_param_sweep();
    exp_t e;
    logic [3:0] er;
    int r;
    @(negedge clk);
    reset_n2 = 1'b1;
    r = edge_n + 1;
    sb_push(r+2, 4'h0, 0, 3'b000); sb_push(r+3, 4'h1, 1, 3'b000);
    sb_push(r+5, 4'h1, 1, 3'b000); sb_push(r+6, 4'h0, 0, 3'b100);
    sb_push(r+7, 4'h1, 1, 3'b100);
    for (int c = 0; c < 30 && sb.size() > 0; c++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].edge_no == edge_n) begin
        e = sb.pop_front();
        er = e.rst;
        checks += 3;
        if (rst_out_n2 !== er[0:0]) begin failures++; $display("FAIL sweep rst_out_n @R+%0d got %b want %b", edge_n-r, rst_out_n2, er[0]); end
        if (seq_done2 !== e.done) begin failures++; $display("FAIL sweep seq_done @R+%0d got %b want %b", edge_n-r, seq_done2, e.done); end
        if (rst_cause2 !== e.cause) begin failures++; $display("FAIL sweep rst_cause @R+%0d got %b want %b", edge_n-r, rst_cause2, e.cause); end
      end
      if (edge_n == r + 5) sw_rst2 = 1'b1;
      if (edge_n == r + 6) sw_rst2 = 1'b0;
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sweep timeout pending %0d want 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_sw_reset();
    test_cause_clr();
    test_async_req();
    test_retrigger();
    test_reset_mid_hold();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
